// File: rtl/bist_sequencer.sv
// Multi-round BIST controller. It runs the INIT/RUN/CHECK sequence for each
// round and compares the MISR signature against the golden value in CHECK.
// All outputs are registered. Each output is decoded from the next-state
// value, so an output is valid in the same cycle as the state it describes.
module bist_sequencer #(
    parameter int CNT_W = 16,
    parameter int RND_W = 4,
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] test_len,
    input  logic [RND_W-1:0] num_rounds,
    input  logic [SIG_W-1:0] sig_in,
    input  logic [SIG_W-1:0] golden,
    output logic             init,
    output logic             running,
    output logic             toggle,
    output logic             finish,
    output logic [RND_W-1:0] round_idx,
    output logic             busy,
    output logic             bist_end,
    output logic             pass,
    output logic [RND_W-1:0] fail_round
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [RND_W-1:0] rounds_q, rounds_d;
    logic [RND_W-1:0] round_q, round_d;
    logic             fail_flag_q, fail_flag_d;
    logic [RND_W-1:0] fail_round_q, fail_round_d;
    logic             init_q, init_d;
    logic             running_q, running_d;
    logic             toggle_q, toggle_d;
    logic             finish_q, finish_d;
    logic             busy_q, busy_d;
    logic             bist_end_q, bist_end_d;
    logic             pass_q, pass_d;

    // Next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        rounds_d     = rounds_q;
        round_d      = round_q;
        fail_flag_d  = fail_flag_q;
        fail_round_d = fail_round_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d        = test_len;
                    // A round count of zero is treated as a single round.
                    rounds_d     = (num_rounds == '0) ? RND_W'(1) : num_rounds;
                    round_d      = '0;
                    cnt_d        = '0;
                    fail_flag_d  = 1'b0;
                    fail_round_d = '0;
                    state_d      = S_INIT;
                end
            end
            S_INIT: begin
                cnt_d   = '0;
                state_d = (len_q == '0) ? S_CHECK : S_RUN;
            end
            S_RUN: begin
                if (cnt_q == len_q - CNT_W'(1)) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                // Only the first mismatching round is recorded.
                if ((sig_in != golden) && !fail_flag_q) begin
                    fail_flag_d  = 1'b1;
                    fail_round_d = round_q;
                end
                if (round_q == rounds_q - RND_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + RND_W'(1);
                    state_d = S_INIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An abort while busy takes priority over the sequencing above.
        if (abort && (state_q == S_INIT || state_q == S_RUN || state_q == S_CHECK)) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            round_d      = '0;
            fail_flag_d  = 1'b0;
            fail_round_d = '0;
        end

        init_d     = (state_d == S_INIT);
        running_d  = (state_d == S_RUN);
        finish_d   = (state_d == S_CHECK);
        busy_d     = (state_d == S_INIT) || (state_d == S_RUN) || (state_d == S_CHECK);
        bist_end_d = (state_d == S_DONE);
        pass_d     = (state_d == S_DONE) && !fail_flag_d;
        // Even RUN cycles strobe high. The last RUN cycle is always low.
        toggle_d   = (state_d == S_RUN) && (cnt_d != len_d - CNT_W'(1)) && !cnt_d[0];
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            rounds_q     <= '0;
            round_q      <= '0;
            fail_flag_q  <= 1'b0;
            fail_round_q <= '0;
            init_q       <= 1'b0;
            running_q    <= 1'b0;
            toggle_q     <= 1'b0;
            finish_q     <= 1'b0;
            busy_q       <= 1'b0;
            bist_end_q   <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            rounds_q     <= rounds_d;
            round_q      <= round_d;
            fail_flag_q  <= fail_flag_d;
            fail_round_q <= fail_round_d;
            init_q       <= init_d;
            running_q    <= running_d;
            toggle_q     <= toggle_d;
            finish_q     <= finish_d;
            busy_q       <= busy_d;
            bist_end_q   <= bist_end_d;
            pass_q       <= pass_d;
        end
    end

    assign init       = init_q;
    assign running    = running_q;
    assign toggle     = toggle_q;
    assign finish     = finish_q;
    assign round_idx  = round_q;
    assign busy       = busy_q;
    assign bist_end   = bist_end_q;
    assign pass       = pass_q;
    assign fail_round = fail_round_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer. The reference model derives the expected outputs
// for every cycle from arithmetic on the cycle count since start. Each round
// occupies L+2 cycles, made up of one INIT cycle, L RUN cycles and one CHECK
// cycle. DONE follows the last round.
module tb_bist_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] test_len = '0;
    logic [3:0]  num_rounds = '0;
    logic [15:0] sig_in = '0;
    logic [15:0] golden = '0;
    logic        init, running, toggle, finish, busy, bist_end, pass;
    logic [3:0]  round_idx, fail_round;

    int errors = 0;
    int checks = 0;

    bist_sequencer #(.CNT_W(16), .RND_W(4), .SIG_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .test_len(test_len), .num_rounds(num_rounds),
        .sig_in(sig_in), .golden(golden),
        .init(init), .running(running), .toggle(toggle), .finish(finish),
        .round_idx(round_idx), .busy(busy), .bist_end(bist_end),
        .pass(pass), .fail_round(fail_round)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch a test and check every cycle through DONE, plus `extra` DONE cycles.
    task automatic run_test(input int L, input int R, input logic [15:0] mism,
                            input int extra, input string name);
        int reff, last, t, rnd, off, j, first_fail;
        logic [6:0] e, o;
        reff = (R == 0) ? 1 : R;
        last = reff * (L + 2);
        first_fail = -1;
        for (int r = 0; r < reff; r++)
            if (mism[r] && first_fail < 0) first_fail = r;
        start = 1'b1;
        test_len = L[15:0];
        num_rounds = R[3:0];
        step();
        start = 1'b0;
        for (int k = 1; k <= last + extra; k++) begin
            rnd = 0;
            if (k <= last) begin
                t = k - 1;
                rnd = t / (L + 2);
                off = t % (L + 2);
                j = off - 1;
                e = {off == 0, (off >= 1 && off <= L),
                     (off >= 1 && off <= L && j != L - 1 && (j % 2) == 0),
                     off == L + 1, 1'b1, 1'b0, 1'b0};
            end else begin
                e = {5'b0, 1'b1, first_fail < 0};
            end
            o = {init, running, toggle, finish, busy, bist_end, pass};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cyc %0d outputs{init,run,tog,fin,busy,end,pass} got %b want %b",
                         name, k, o, e);
            end
            if (k <= last) begin
                checks++;
                if (round_idx !== rnd[3:0]) begin
                    errors++;
                    $display("FAIL %s cyc %0d round_idx got %0d want %0d", name, k, round_idx, rnd);
                end
            end else if (first_fail >= 0) begin
                checks++;
                if (fail_round !== first_fail[3:0]) begin
                    errors++;
                    $display("FAIL %s cyc %0d fail_round got %0d want %0d", name, k, fail_round, first_fail);
                end
            end
            // Scramble the config, which is not latched mid-test. Mismatch the
            // signature on the rounds flagged in mism, and pulse start while
            // busy so that the DUT has to ignore it.
            test_len = 16'($urandom);
            num_rounds = 4'($urandom);
            golden = 16'($urandom);
            sig_in = (k <= last && mism[rnd]) ? (golden ^ 16'h0101) : golden;
            start = (k <= last) ? ($urandom_range(0, 3) == 0) : 1'b0;
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] o;
        reset = 1'b1; start = 1'b1; abort = 1'b1; test_len = 16'd5; num_rounds = 4'd1;
        step(); step();
        o = {init, running, toggle, finish, busy, bist_end, pass, round_idx, fail_round};
        checks++;
        if (o !== 15'b0) begin
            errors++;
            $display("FAIL reset outputs got %h want 0", o);
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        step();
        o = {init, running, toggle, finish, busy, bist_end, pass, round_idx, fail_round};
        checks++;
        if (o !== 15'b0) begin
            errors++;
            $display("FAIL idle_after_reset outputs got %h want 0", o);
        end
    endtask

    task automatic test_abort();
        logic [6:0] o;
        start = 1'b1; test_len = 16'd10; num_rounds = 4'd2;
        step();
        start = 1'b0;
        // Round 1 runs from cycle 13 (INIT) through 24 (CHECK). Abort at cycle 18.
        for (int k = 1; k < 18; k++) step();
        checks++;
        if (running !== 1'b1 || round_idx !== 4'd1) begin
            errors++;
            $display("FAIL abort_pre running=%b round_idx=%0d want 1/1", running, round_idx);
        end
        abort = 1'b1;
        step();
        o = {init, running, toggle, finish, busy, bist_end, pass};
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL abort outputs got %b want 0", o);
        end
        // An abort while idle is ignored.
        step();
        abort = 1'b0;
        o = {init, running, toggle, finish, busy, bist_end, pass};
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL abort_idle outputs got %b want 0", o);
        end
        run_test(6, 1, 16'h0000, 2, "after_abort");
    endtask

    task automatic test_reset_in_check();
        logic [14:0] o;
        start = 1'b1; test_len = 16'd3; num_rounds = 4'd2;
        step();
        start = 1'b0;
        for (int k = 1; k < 5; k++) step();
        checks++;
        if (finish !== 1'b1) begin
            errors++;
            $display("FAIL rst_chk_pre finish got %b want 1", finish);
        end
        reset = 1'b1; abort = 1'b1; start = 1'b1;
        golden = 16'h1234; sig_in = 16'h4321;
        step();
        o = {init, running, toggle, finish, busy, bist_end, pass, round_idx, fail_round};
        checks++;
        if (o !== 15'b0) begin
            errors++;
            $display("FAIL rst_in_check outputs got %h want 0", o);
        end
        reset = 1'b0; abort = 1'b0; start = 1'b0; sig_in = golden;
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++)
            run_test($urandom_range(0, 12), $urandom_range(0, 5), 16'($urandom), 2, "random");
    endtask

    initial begin
        test_reset();
        run_test(5, 1, 16'h0000, 3, "basic");
        run_test(4, 3, 16'h0002, 2, "multi_round");
        run_test(5, 1, 16'h0000, 2, "restart");
        run_test(0, 2, 16'h0000, 2, "zero_len");
        run_test(3, 0, 16'h0001, 2, "zero_rounds");
        test_abort();
        test_reset_in_check();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
